// File: rtl/d_debounce.sv
// d_debounce: synchronises a raw level and only passes changes that hold for STABLE_CYCLES samples.
module d_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d,
  output logic rise,
  output logic fall,
  output logic busy
);
  typedef enum logic {STABLE, CHECK} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic d_q, d_d, rise_q, rise_d, fall_q, fall_d;
  logic d_sync;
  assign d_sync = s_q[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s_q     <= {s_q[SYNC_STAGES-2:0], d_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  // cnt counts agreeing samples; the last one flips d and fires the matching strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    d_d     = d_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (d_sync != d_q) begin
      if (state_q == STABLE) begin
        state_d = CHECK;
        cnt_d   = CNT_W'(1);
      end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
        state_d = STABLE;
        d_d     = ~d_q;
        rise_d  = ~d_q;
        fall_d  = d_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      state_d = STABLE;
    end
  end
  assign d    = d_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == CHECK);
endmodule

// File: tb/tb_d_debounce.sv
// tb_d_debounce: directed scenarios for d_debounce at default parameters.
module tb_d_debounce;
  logic clk, rst, d_in;
  logic d, rise, fall, busy;
  int errors = 0;
  int checks = 0;

  d_debounce dut (
    .clk  (clk),
    .rst  (rst),
    .d_in (d_in),
    .d    (d),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    d_in = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    d_in = 1'b1;
    rst  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({d, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold k=%0d got=%b exp=0000", k, {d, rise, fall, busy});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {k >= 6, k == 6, 1'b0, k >= 3 && k <= 5};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL reset_release k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_clean_edge();
    logic [3:0] exp;
    apply_reset();
    d_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {k >= 6, k == 6, 1'b0, k >= 3 && k <= 5};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL clean_rise k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
    d_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {k < 6, 1'b0, k == 6, k >= 3 && k <= 5};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL clean_fall k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp;
    apply_reset();
    d_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) d_in = 1'b0;
      exp = {3'b000, k >= 3 && k <= 5};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL glitch k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_min_pulse();
    logic [3:0] exp;
    apply_reset();
    d_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) d_in = 1'b0;
      exp = {k >= 6 && k <= 9, k == 6, k == 10, (k >= 3 && k <= 5) || (k >= 7 && k <= 9)};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL min_pulse k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp;
    logic [8:0] pat;
    logic [15:0] bexp;
    pat  = 9'b111101101;
    bexp = 16'h0768;
    apply_reset();
    d_in = pat[0];
    for (int k = 1; k <= 14; k++) begin
      tick();
      d_in = (k < 9) ? pat[k] : 1'b1;
      exp = {k >= 11, k == 11, 1'b0, bexp[k]};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    apply_reset();
    d_in = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if ({d, rise, fall, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_before got=%b exp=0001", {d, rise, fall, busy});
    end
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if ({d, rise, fall, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async got=%b exp=0000", {d, rise, fall, busy});
    end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = {k >= 6, k == 6, 1'b0, k >= 3 && k <= 5};
      checks++;
      if ({d, rise, fall, busy} !== exp) begin
        errors++;
        $display("FAIL mid_release k=%0d got=%b exp=%b", k, {d, rise, fall, busy}, exp);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    d_in = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_min_pulse();
    test_bounce();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
